hilo_muldiv_sequencer: RTL

// - Iterative multiply/divide sequencer owning the HI/LO write port of the pipelined MIPS core.
// - Accepts MULT/MULTU/DIV/DIVU from EX, computes over multiple cycles, writes the 64-bit result to HiLoRegisters once.
// - Raises a stall request when decode reads HI/LO, or issues a new mul/div, while an operation is in flight.

---
 rtl/hilo_muldiv_if.sv | 29 ++
 rtl/hilo_muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between EX, decode and the HI/LO multiply/divide sequencer.
// master: the issuing pipeline side; slave: the sequencer.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Cancel;
    logic             HiLoRead;
    logic             Busy;
    logic             StallReq;
    logic             Done;
    logic             HiLoWrite;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             DivByZero;

    modport master (
        output Start, Op, OperandA, OperandB, Cancel, HiLoRead,
        input  Busy, StallReq, Done, HiLoWrite, HiOut, LoOut, DivByZero
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Cancel, HiLoRead,
        output Busy, StallReq, Done, HiLoWrite, HiOut, LoOut, DivByZero
    );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write port (radix-2, one step per cycle).
// Optional macro FAST_MULT_EN: MULT/MULTU use a single-cycle multiplier in PREP; division stays iterative.
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         Clk,
    input  logic         Rst,
    hilo_muldiv_if.slave bus
);

    localparam int DW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_op;
    logic signed [WIDTH-1:0] r_opa;
    logic signed [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0]        r_m;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;
    logic                    r_neg_res;
    logic                    r_neg_rem;
    logic [WIDTH-1:0]        r_hi_out;
    logic [WIDTH-1:0]        r_lo_out;
    logic                    r_dbz;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_is_div;
    logic                    w_signed;
    logic                    w_div_zero;
    logic                    w_load_out;
    logic [WIDTH-1:0]        w_mag_a;
    logic [WIDTH-1:0]        w_mag_b;
    logic [WIDTH:0]          w_add;
    logic [WIDTH:0]          w_shift;
    logic [WIDTH+1:0]        w_diff;
    logic                    w_borrow;
    logic [WIDTH-1:0]        w_step_hi;
    logic [WIDTH-1:0]        w_step_lo;
    logic [DW-1:0]           w_prod_neg;
    logic [WIDTH-1:0]        w_fix_hi;
    logic [WIDTH-1:0]        w_fix_lo;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [DW-1:0] f_neg2(input logic [DW-1:0] v);
        return ~v + DW'(1);
    endfunction

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? f_neg(u) : u;
    endfunction

    assign w_is_div   = r_op[1];
    assign w_signed   = ~r_op[0];
    assign w_div_zero = w_is_div && (r_opb == '0);
    assign w_mag_a    = w_signed ? f_abs(r_opa) : r_opa;
    assign w_mag_b    = w_signed ? f_abs(r_opb) : r_opb;

`ifdef FAST_MULT_EN
    logic [DW-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

    // Shift-add multiply: r_hi accumulates, r_lo holds the multiplier and collects product LSBs.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_m};
    assign w_borrow = |w_diff[WIDTH+1:WIDTH];

    always_comb begin
        if (w_is_div) begin
            w_step_hi = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], ~w_borrow};
        end else begin
            w_step_hi = w_add[WIDTH:1];
            w_step_lo = {w_add[0], r_lo[WIDTH-1:1]};
        end
    end

    assign w_prod_neg = f_neg2({r_hi, r_lo});

    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        if (w_is_div) begin
            if (r_neg_res) w_fix_lo = f_neg(r_lo);
            if (r_neg_rem) w_fix_hi = f_neg(r_hi);
        end else if (r_neg_res) begin
            w_fix_hi = w_prod_neg[DW-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
    end

    // Cancel aborts any state except DONE, whose write is already committed.
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start && !bus.Cancel) w_state_nxt = PREP;
            end
            PREP: begin
                if (bus.Cancel) begin
                    w_state_nxt = IDLE;
                end else if (w_div_zero) begin
                    w_state_nxt = DONE;
                    w_load_out  = 1'b1;
                end
`ifdef FAST_MULT_EN
                else if (!w_is_div) begin
                    w_state_nxt = FIX;
                end
`endif
                else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.Cancel)              w_state_nxt = IDLE;
                else if (r_cnt == LAST_STEP) w_state_nxt = FIX;
            end
            FIX: begin
                if (bus.Cancel) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                    w_load_out  = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == PREP)     r_cnt <= '0;
            else if (r_state == RUN) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    r_op  <= bus.Op;
                    r_opa <= bus.OperandA;
                    r_opb <= bus.OperandB;
                end
            end
            PREP: begin
                r_neg_res <= w_signed & (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]);
                r_neg_rem <= w_signed & r_opa[WIDTH-1];
                r_m       <= w_is_div ? w_mag_b : w_mag_a;
                r_hi      <= '0;
                r_lo      <= w_is_div ? w_mag_a : w_mag_b;
`ifdef FAST_MULT_EN
                if (!w_is_div) begin
                    r_hi <= w_fast_prod[DW-1:WIDTH];
                    r_lo <= w_fast_prod[WIDTH-1:0];
                end
`endif
            end
            RUN: begin
                r_hi <= w_step_hi;
                r_lo <= w_step_lo;
            end
            default: ;
        endcase
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hi_out <= '0;
            r_lo_out <= '0;
            r_dbz    <= 1'b0;
        end else if (w_load_out) begin
            if (r_state == PREP) begin
                r_hi_out <= r_opa;
                r_lo_out <= '1;
                r_dbz    <= 1'b1;
            end else begin
                r_hi_out <= w_fix_hi;
                r_lo_out <= w_fix_lo;
                r_dbz    <= 1'b0;
            end
        end
    end

    assign w_busy        = (r_state != IDLE);
    assign w_done        = (r_state == DONE);
    assign bus.Busy      = w_busy;
    assign bus.StallReq  = w_busy & (bus.HiLoRead | bus.Start);
    assign bus.Done      = w_done;
    assign bus.HiLoWrite = w_done;
    assign bus.DivByZero = w_done & r_dbz;
    assign bus.HiOut     = r_hi_out;
    assign bus.LoOut     = r_lo_out;

endmodule
